// File: rtl/tea_pkg.sv
// rtl/tea_pkg.sv - TEA constants, state encoding and round helpers shared by tea_sched (TEA_DECRYPT_EN aware).
package tea_pkg;

  localparam logic [31:0] DELTA      = 32'h9E3779B9;
  localparam int          ROUNDS_DEF = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Decrypt starts from the sum encrypt would finish with.
  function automatic logic [31:0] dec_sum_init(input int rounds);
    return DELTA * 32'(rounds);
  endfunction

  function automatic logic [31:0] tea_f(input logic [31:0] x, input logic [31:0] sum,
                                        input logic [31:0] ka, input logic [31:0] kb);
    return ((x << 4) + ka) ^ (x + sum) ^ ((x >> 5) + kb);
  endfunction

endpackage

// File: rtl/tea_round.sv
// rtl/tea_round.sv - combinational single TEA round; TEA_DECRYPT_EN adds the inverse round path.
module tea_round
  import tea_pkg::*;
(
  input  logic [31:0]  v0,
  input  logic [31:0]  v1,
  input  logic [31:0]  sum,
  input  logic [127:0] key,
`ifdef TEA_DECRYPT_EN
  input  logic         mode,
`endif
  output logic [31:0]  v0_next,
  output logic [31:0]  v1_next
);

  logic [31:0] k0, k1, k2, k3;
  logic [31:0] enc_v0, enc_v1;

  assign {k3, k2, k1, k0} = key;

  // The second half-round always consumes the freshly updated word.
  assign enc_v0 = v0 + tea_f(v1, sum, k0, k1);
  assign enc_v1 = v1 + tea_f(enc_v0, sum, k2, k3);

`ifdef TEA_DECRYPT_EN
  logic [31:0] dec_v0, dec_v1;

  assign dec_v1  = v1 - tea_f(v0, sum, k2, k3);
  assign dec_v0  = v0 - tea_f(dec_v1, sum, k0, k1);
  assign v0_next = mode ? dec_v0 : enc_v0;
  assign v1_next = mode ? dec_v1 : enc_v1;
`else
  assign v0_next = enc_v0;
  assign v1_next = enc_v1;
`endif

endmodule

// File: rtl/tea_sched.sv
// rtl/tea_sched.sv - two-port round-robin scheduler over one iterative TEA round; TEA_DECRYPT_EN adds req_dec/decrypt.
module tea_sched
  import tea_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [63:0]  req_v0,
  input  logic [63:0]  req_v1,
  input  logic [255:0] req_key,
`ifdef TEA_DECRYPT_EN
  input  logic [1:0]   req_dec,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_v0,
  output logic [31:0]  out_v1,
  output logic         out_id
);

  state_t       state, state_n;
  logic         last_grant, grant, id;
  logic [31:0]  v0, v1, sum, v0_n, v1_n;
  logic [127:0] key;
  logic [5:0]   cnt;
`ifdef TEA_DECRYPT_EN
  logic         mode;
`endif

  // Only a contested cycle consults the pointer; a lone requester wins outright.
  assign grant = (&req_valid) ? ~last_grant : req_valid[1];

  tea_round u_round (
    .v0      (v0),
    .v1      (v1),
    .sum     (sum),
    .key     (key),
`ifdef TEA_DECRYPT_EN
    .mode    (mode),
`endif
    .v0_next (v0_n),
    .v1_next (v1_n)
  );

  always_comb begin
    state_n   = state;
    req_ready = 2'b00;
    case (state)
      IDLE: if (req_valid[grant]) begin
        req_ready[grant] = 1'b1;
        state_n          = RUN;
      end
      RUN:  if (cnt == 6'(ROUNDS - 1)) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      v0         <= '0;
      v1         <= '0;
      sum        <= '0;
      key        <= '0;
      cnt        <= '0;
      id         <= 1'b0;
`ifdef TEA_DECRYPT_EN
      mode       <= 1'b0;
`endif
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (req_valid[grant]) begin
          v0  <= grant ? req_v0[63:32] : req_v0[31:0];
          v1  <= grant ? req_v1[63:32] : req_v1[31:0];
          key <= grant ? req_key[255:128] : req_key[127:0];
          id  <= grant;
          cnt <= '0;
`ifdef TEA_DECRYPT_EN
          mode <= req_dec[grant];
          sum  <= req_dec[grant] ? dec_sum_init(ROUNDS) : DELTA;
`else
          sum  <= DELTA;
`endif
        end
        RUN: begin
          v0  <= v0_n;
          v1  <= v1_n;
          cnt <= cnt + 6'd1;
`ifdef TEA_DECRYPT_EN
          sum <= mode ? sum - DELTA : sum + DELTA;
`else
          sum <= sum + DELTA;
`endif
        end
        DONE: if (out_ready) last_grant <= id;
        default: ;
      endcase
    end
  end

  // Working registers double as the output registers; they only move in IDLE/RUN.
  assign out_valid = (state == DONE);
  assign out_v0    = v0;
  assign out_v1    = v1;
  assign out_id    = id;

endmodule

// File: tb/tb_tea_sched.sv
// tb/tb_tea_sched.sv - self-checking bench for tea_sched with a reference TEA scoreboard (TEA_DECRYPT_EN aware).
module tb_tea_sched;

  localparam int          R   = 32;
  localparam logic [31:0] DLT = 32'h9E3779B9;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [63:0]  req_v0 = '0;
  logic [63:0]  req_v1 = '0;
  logic [255:0] req_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_v0, out_v1;
  logic         out_id;
  logic [1:0]   dec_in;
`ifdef TEA_DECRYPT_EN
  logic [1:0]   req_dec = 2'b00;
  assign dec_in = req_dec;
`else
  assign dec_in = 2'b00;
`endif

  tea_sched #(.ROUNDS(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_v0    (req_v0),
    .req_v1    (req_v1),
    .req_key   (req_key),
`ifdef TEA_DECRYPT_EN
    .req_dec   (req_dec),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_v0    (out_v0),
    .out_v1    (out_v1),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Plain textbook TEA, written as the usual software loop.
  function automatic logic [63:0] tea_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [127:0] k, input bit dec);
    logic [31:0] y, z, s, k0, k1, k2, k3;
    y = a; z = b;
    {k3, k2, k1, k0} = k;
    s = dec ? DLT * 32'(R) : DLT;
    for (int i = 0; i < R; i++) begin
      if (!dec) begin
        y += ((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1);
        z += ((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3);
        s += DLT;
      end else begin
        z -= ((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3);
        y -= ((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1);
        s -= DLT;
      end
    end
    return {y, z};
  endfunction

  // Scoreboard: grant rule, latency and result of each accepted block.
  bit          m_busy = 1'b0;
  bit          m_last = 1'b1;
  int          m_age = 0;
  logic [63:0] m_res = '0;
  bit          m_id = 1'b0;

  initial forever begin
    logic       g;
    logic [1:0] er;
    bit         ov;
    @(negedge clk);
    if (rst) begin
      m_busy = 1'b0;
      m_last = 1'b1;
      m_age  = 0;
    end else begin
      g  = (req_valid == 2'b11) ? ~m_last : req_valid[1];
      er = (!m_busy && req_valid[g]) ? (g ? 2'b10 : 2'b01) : 2'b00;
      chk("req_ready", 64'(req_ready), 64'(er));
      if (m_busy) m_age++;
      ov = m_busy && (m_age >= R + 1);
      chk("out_valid", 64'(out_valid), 64'(ov));
      if (ov) begin
        chk("out_data", {out_v0, out_v1}, m_res);
        chk("out_id", 64'(out_id), 64'(m_id));
        if (out_ready) begin
          m_busy = 1'b0;
          m_last = m_id;
        end
      end else if (!m_busy && req_valid[g]) begin
        m_res  = tea_ref(g ? req_v0[63:32] : req_v0[31:0], g ? req_v1[63:32] : req_v1[31:0],
                         g ? req_key[255:128] : req_key[127:0], g ? dec_in[1] : dec_in[0]);
        m_id   = g;
        m_busy = 1'b1;
        m_age  = 0;
      end
    end
  end

  task automatic load(input int p, input logic [31:0] a, input logic [31:0] b,
                      input logic [127:0] k, input bit d);
    req_v0[32*p +: 32]   = a;
    req_v1[32*p +: 32]   = b;
    req_key[128*p +: 128] = k;
`ifdef TEA_DECRYPT_EN
    req_dec[p] = d;
`else
    if (d) $display("decrypt requested in encrypt-only build");
`endif
  endtask

  task automatic wait_ready(input int p, output int acc);
    acc = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (req_ready[p]) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) timeout("accept");
  endtask

  task automatic send(input int p, input logic [31:0] a, input logic [31:0] b,
                      input logic [127:0] k, input bit d, output int acc);
    @(posedge clk); #1;
    load(p, a, b, k, d);
    req_valid[p] = 1'b1;
    wait_ready(p, acc);
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_out(output int c);
    c = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (out_valid) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) timeout("out_valid");
  endtask

  initial begin
    int          acc, c, p;
    logic [31:0] a, b;
    logic [127:0] k;
    logic [63:0] e;

    chk("model_kat", tea_ref(32'h0, 32'h0, 128'h0, 1'b0), 64'h41EA3A0A_94BAA940);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", {out_v0, out_v1}, 64'h0);
    chk("rst_out_id", 64'(out_id), 64'h0);

    // Both ports contend continuously: grants must alternate from port 0.
    @(posedge clk); #1;
    load(0, $urandom, $urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    load(1, $urandom, $urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      p = -1;
      for (int n = 0; n < 100; n++) begin
        @(negedge clk);
        if (req_ready != 2'b00) begin
          p = int'(req_ready[1]);
          break;
        end
      end
      if (p < 0) timeout("grant_order");
      else begin
        chk("grant_order", 64'(req_ready), (i % 2 == 1) ? 64'h2 : 64'h1);
        @(posedge clk); #1;
        load(p, $urandom, $urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
      end
    end
    req_valid = 2'b00;
    repeat (40) @(posedge clk);

    // Output stall with a pending port-0 request, then port 1 arrives in the handshake cycle.
    out_ready = 1'b0;
    a = 32'h01234567; b = 32'h89ABCDEF; k = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    e = tea_ref(a, b, k, 1'b0);
    send(0, a, b, k, 1'b0, acc);
    wait_out(c);
    @(posedge clk); #1;
    load(0, 32'h5, 32'h6, 128'h7, 1'b0);
    req_valid = 2'b01;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_out_valid", 64'(out_valid), 64'h1);
      chk("stall_out_data", {out_v0, out_v1}, e);
      chk("stall_req_ready", 64'(req_ready), 64'h0);
    end
    @(posedge clk); #1;
    load(1, 32'hCAFEF00D, 32'h0BADBEEF, 128'h1, 1'b0);
    req_valid = 2'b10;
    out_ready = 1'b1;
    @(negedge clk);
    chk("hs_req_ready", 64'(req_ready), 64'h0);
    chk("hs_out_valid", 64'(out_valid), 64'h1);
    @(negedge clk);
    chk("post_hs_req_ready", 64'(req_ready), 64'h2);
    chk("post_hs_out_valid", 64'(out_valid), 64'h0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_out(c);
    chk("p1_out_id", 64'(out_id), 64'h1);
    chk("p1_out_data", {out_v0, out_v1}, tea_ref(32'hCAFEF00D, 32'h0BADBEEF, 128'h1, 1'b0));
    repeat (2) @(posedge clk);

    // Known-answer block on port 0 with latency.
    send(0, 32'h0, 32'h0, 128'h0, 1'b0, acc);
    wait_out(c);
    chk("latency", 64'(c - acc), 64'd33);
    chk("kat_out_v0", 64'(out_v0), 64'h41EA3A0A);
    chk("kat_out_v1", 64'(out_v1), 64'h94BAA940);
    chk("kat_out_id", 64'(out_id), 64'h0);
    repeat (3) @(posedge clk);

`ifdef TEA_DECRYPT_EN
    send(0, 32'h41EA3A0A, 32'h94BAA940, 128'h0, 1'b1, acc);
    wait_out(c);
    chk("dec_kat", {out_v0, out_v1}, 64'h0);
    repeat (2) @(posedge clk);
    a = $urandom; b = $urandom; k = {$urandom, $urandom, $urandom, $urandom};
    send(1, a, b, k, 1'b0, acc);
    wait_out(c);
    e = {out_v0, out_v1};
    repeat (2) @(posedge clk);
    send(0, e[63:32], e[31:0], k, 1'b1, acc);
    wait_out(c);
    chk("roundtrip", {out_v0, out_v1}, {a, b});
    repeat (2) @(posedge clk);
`endif

    // Reset mid-run abandons the block and restores port-0 priority.
    send(1, 32'h13579BDF, 32'h2468ACE0, 128'hFEEDFACE, 1'b0, acc);
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'h0);
    chk("midrst_out_data", {out_v0, out_v1}, 64'h0);
    chk("midrst_out_id", 64'(out_id), 64'h0);
    chk("midrst_req_ready", 64'(req_ready), 64'h0);
    @(posedge clk); #1;
    load(0, 32'hA5A5A5A5, 32'h5A5A5A5A, 128'h3, 1'b0);
    load(1, 32'h11111111, 32'h22222222, 128'h4, 1'b0);
    req_valid = 2'b11;
    @(negedge clk);
    chk("midrst_priority", 64'(req_ready), 64'h1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_out(c);
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tea_sched.md
# tea_sched

Two-requester round-robin scheduler wrapped around one shared iterative TEA round unit. Each requester submits a 64-bit block and a 128-bit key through a valid/ready handshake. The block grants one requester, runs ROUNDS single-cycle TEA rounds on the shared round logic, and returns the result on a valid/ready output tagged with the requester ID. It is the low-area alternative to the fully unrolled pipeline, for ports that share one crypto resource.

## Interface
- ROUNDS, 32: TEA cycles per block; range 1..63.
- DELTA, 32'h9E3779B9: key-schedule constant.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  2  per-port request valid; bit p belongs to port p.
- req_ready  out  2  per-port accept; at most one bit high.
- req_v0  in  64  port p word v0 at [32p+31:32p].
- req_v1  in  64  port p word v1 at [32p+31:32p].
- req_key  in  256  port p key {k3,k2,k1,k0} at [128p+127:128p].
- req_dec  in  2  per-port decrypt select; present only with TEA_DECRYPT_EN.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_v0, out_v1  out  32 each  result words.
- out_id  out  1  index of the port that owns the result.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE, grant selection:
  - Grant g is the requesting port with priority.
  - When both ports request, the port not granted last wins.
  - After reset, port 0 has priority.
- IDLE, acceptance: req_ready[g] is high combinationally while req_valid[g] is high.
- IDLE, on the accepting edge:
  - Capture v0, v1, key, mode and id = g.
  - Encrypt: sum = DELTA. Decrypt: sum = DELTA*ROUNDS mod 2^32 (0xC6EF3720 for 32).
  - Clear the round counter and go to RUN.
- RUN performs one full round per cycle in tea_round.
- Encrypt round:
  - v0 += ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1).
  - Then v1 += ((v0'<<4)+k2) ^ (v0'+sum) ^ ((v0'>>5)+k3), using the new v0'.
  - Then sum += DELTA.
- Decrypt round:
  - v1 -= f(v0, sum, k2, k3).
  - Then v0 -= f(v1', sum, k0, k1), using the new v1'.
  - Then sum -= DELTA.
- Arithmetic rules: all arithmetic is mod 2^32, and >> is a logical shift.
- Round counter: 6 bits. When the counter reaches ROUNDS-1, that round's edge moves the FSM to DONE.
- DONE:
  - out_valid is high. out_v0, out_v1 and out_id hold stable until out_ready is sampled high.
  - On the handshake edge, go to IDLE and record last_grant = id.
- req_ready is 0 in RUN and DONE. Requesters must hold data and valid until they are accepted.
- A requester may drop req_valid before it is granted; no state is affected.

## Timing
- Reset values:
  - req_ready = 0, out_valid = 0, out_v0 = 0, out_v1 = 0, out_id = 0.
  - Internal state = IDLE, last_grant = 1 (so port 0 is preferred).
- Latency: accept edge E0, rounds on edges E1..E_ROUNDS, out_valid high from the cycle after E_ROUNDS. That is ROUNDS+1 cycles from accept to out_valid.
- Minimum spacing between accepts is ROUNDS+2 cycles. IDLE always lasts at least one cycle after an output handshake.
- A request that is valid in the cycle of the output handshake is accepted at the earliest on the next cycle.
- out_ready held low: the FSM stays in DONE indefinitely and accepts nothing.
- rst mid-RUN or mid-DONE: the block is abandoned. Next cycle all outputs are at reset values and priority returns to port 0.
- out_valid and the output data are registered. req_ready is combinational from FSM state, grant and req_valid only.

## Configuration
- TEA_DECRYPT_EN defined:
  - The req_dec port exists and a per-block mode bit is captured.
  - Decrypt sum init and the decrypt round path are built.
- TEA_DECRYPT_EN undefined:
  - req_dec is absent and the block is encrypt-only.
  - No subtract path and no DELTA*ROUNDS constant are built.

## Structure
- Package tea_pkg contains:
  - DELTA.
  - The default ROUNDS.
  - A function for the decrypt sum init.
  - The state enum {IDLE, RUN, DONE}.
  - The round function f(x, sum, ka, kb).
- Sub-module tea_round: combinational single round. Inputs v0, v1, sum, key and mode (mode only under TEA_DECRYPT_EN). Outputs the new v0 and v1.
- tea_sched contains the FSM, the round-robin pointer, the working registers and the counter.

## Test plan
- Port 0 only, encrypt, v0=v1=0, key=0 -> out_v0=0x41EA3A0A, out_v1=0x94BAA940, out_id=0; out_valid rises 33 cycles after accept.
- Both ports valid continuously with distinct data -> grants alternate 0,1,0,1. Each out_id matches its owner and each result matches a software TEA model.
- out_ready low for 10 cycles in DONE -> outputs stable, out_valid stays high, req_ready stays 0. Then out_ready=1 -> one handshake, IDLE next cycle.
- TEA_DECRYPT_EN: decrypt v0=0x41EA3A0A, v1=0x94BAA940, key=0 -> 0,0. Also a random encrypt then decrypt round-trip returns the original plaintext.
- rst asserted at round 15 -> next cycle out_valid=0, outputs 0, state IDLE. A subsequent request with port 1 and port 0 both valid grants port 0.
- Port 1 raises req_valid in the same cycle as the output handshake -> req_ready[1] stays 0 that cycle and goes high in the following cycle.
